// File: rtl/pc_next_unit.sv
// Next-PC generator and PC register with a circular return-address stack.
// Rejected misaligned jr targets hold the PC and raise a one-cycle pulse.
module pc_next_unit #(
  parameter int          XLEN      = 32,
  parameter int          IMM_W     = 16,
  parameter int          JT_W      = 26,
  parameter int          RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            pc_write,
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  input  logic [IMM_W-1:0] imm,
  input  logic [JT_W-1:0] jtarget,
  input  logic [XLEN-1:0] rs_value,
  input  logic            push_ra,
  input  logic            pop_ra,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misaligned
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic            mis_q, mis_d;

  logic [XLEN-1:0] imm_ext, br_tgt, jmp_tgt, jr_tgt, tgt;
  logic [PW-1:0]   wptr;
  logic            is_jr, use_ras, bad, commit;
  logic            do_push, do_pop, wr_en;
  logic [PW-1:0]   wr_idx;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign pc        = pc_q;
  assign misaligned = mis_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_top   = ras_empty ? '0 : ras_q[ptr_q];

  assign imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign br_tgt  = branch_taken ? pc_plus4 + (imm_ext << 2) : pc_plus4;
  assign jmp_tgt = {pc_plus4[XLEN-1:JT_W+2], jtarget, 2'b00};

  assign is_jr   = (pc_src == 2'b11);
  assign use_ras = is_jr && pop_ra && !ras_empty;
  assign jr_tgt  = use_ras ? ras_top : rs_value;
  assign bad     = is_jr && (jr_tgt[1:0] != 2'b00);
  assign commit  = pc_write && !bad;
  assign do_push = commit && push_ra;
  assign do_pop  = commit && use_ras;
  assign wptr    = ptr_q + PW'(1);

  always_comb begin
    tgt = pc_plus4;
    case (pc_src)
      2'b00:   tgt = pc_plus4;
      2'b01:   tgt = br_tgt;
      2'b10:   tgt = jmp_tgt;
      default: tgt = jr_tgt;
    endcase
  end

  always_comb begin
    pc_d   = commit ? tgt : pc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    mis_d  = pc_write && bad;
    // push+pop on a non-empty stack swaps the top in place
    if (do_push && do_pop) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (do_push) begin
      wr_en  = 1'b1;
      wr_idx = wptr;
      ptr_d  = wptr;
      if (!ras_full) cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
      if (wr_en) ras_q[wr_idx] <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Table-driven directed checks for pc_next_unit.
// Vectors are applied one clock each; state carries between rows.
module tb_pc_next_unit;

  logic        CLK = 1'b0;
  logic        Reset, pc_write, branch_taken, push_ra, pop_ra;
  logic [1:0]  pc_src;
  logic [15:0] imm;
  logic [25:0] jtarget;
  logic [31:0] rs_value;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        ras_empty, ras_full, misaligned;

  int total = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  pc_next_unit dut (
    .CLK(CLK), .Reset(Reset), .pc_write(pc_write), .pc_src(pc_src),
    .branch_taken(branch_taken), .imm(imm), .jtarget(jtarget),
    .rs_value(rs_value), .push_ra(push_ra), .pop_ra(pop_ra),
    .pc(pc), .pc_plus4(pc_plus4), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full), .misaligned(misaligned)
  );

  typedef struct {
    logic        rst, we, tk, push, pop;
    logic [1:0]  src;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] rs;
    logic [31:0] epc;
    logic        emis, eemp, efull;
    logic [31:0] etop;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic rst, logic we, logic [1:0] src, logic tk, logic [15:0] im,
    logic [25:0] jt, logic [31:0] rs, logic push, logic pop,
    logic [31:0] epc, logic emis, logic eemp, logic efull,
    logic [31:0] etop);
    vec_t v;
    v.rst = rst; v.we = we; v.src = src; v.tk = tk; v.imm = im;
    v.jt = jt; v.rs = rs; v.push = push; v.pop = pop;
    v.epc = epc; v.emis = emis; v.eemp = eemp; v.efull = efull;
    v.etop = etop;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(vec_t v);
    Reset = v.rst; pc_write = v.we; pc_src = v.src;
    branch_taken = v.tk; imm = v.imm; jtarget = v.jt;
    rs_value = v.rs; push_ra = v.push; pop_ra = v.pop;
  endtask

  task automatic check_vec(int i, vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    check({t, ".pc"}, pc, v.epc);
    check({t, ".pc4"}, pc_plus4, v.epc + 32'd4);
    check({t, ".mis"}, {31'd0, misaligned}, {31'd0, v.emis});
    check({t, ".empty"}, {31'd0, ras_empty}, {31'd0, v.eemp});
    check({t, ".full"}, {31'd0, ras_full}, {31'd0, v.efull});
    check({t, ".top"}, ras_top, v.etop);
  endtask

  initial begin
    //          rst we src tk imm       jt      rs            pu po  pc            mis emp ful top
    vq.push_back(mk(1,0,2'b00,0,16'h0,26'h0,32'h0,       0,0, 32'h0,       0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       0,0, 32'h4,       0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       0,0, 32'h8,       0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       0,0, 32'hC,       0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h100,     0,0, 32'h100,     0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b01,1,16'hFFFF,26'h0,32'h0,    0,0, 32'h100,     0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b01,0,16'hFFFF,26'h0,32'h0,    0,0, 32'h104,     0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'hF0000010,0,0, 32'hF0000010,0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b10,0,16'h0,26'h40,32'h0,      0,0, 32'hF0000100,0,1,0,32'h0));
    vq.push_back(mk(0,0,2'b01,1,16'h5,26'h0,32'h0,       0,0, 32'hF0000100,0,1,0,32'h0));
    vq.push_back(mk(0,0,2'b01,1,16'h5,26'h0,32'h0,       0,0, 32'hF0000100,0,1,0,32'h0));
    vq.push_back(mk(0,0,2'b01,1,16'h5,26'h0,32'h0,       0,0, 32'hF0000100,0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b01,1,16'h3,26'h0,32'h0,       0,0, 32'hF0000110,0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h200,     0,0, 32'h200,     0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       1,0, 32'h204,     0,0,0,32'h204));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       1,0, 32'h208,     0,0,0,32'h208));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       1,0, 32'h20C,     0,0,0,32'h20C));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       1,0, 32'h210,     0,0,1,32'h210));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       1,0, 32'h214,     0,0,1,32'h214));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h40,      0,1, 32'h214,     0,0,0,32'h210));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h40,      0,1, 32'h210,     0,0,0,32'h20C));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h40,      0,1, 32'h20C,     0,0,0,32'h208));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h40,      0,1, 32'h208,     0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h40,      0,1, 32'h40,      0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       1,0, 32'h44,      0,0,0,32'h44));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h102,     0,0, 32'h44,      1,0,0,32'h44));
    vq.push_back(mk(0,0,2'b00,0,16'h0,26'h0,32'h0,       0,0, 32'h44,      0,0,0,32'h44));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h103,     1,0, 32'h44,      1,0,0,32'h44));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h300,     1,1, 32'h44,      0,0,0,32'h48));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       0,1, 32'h48,      0,0,0,32'h48));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h0,       0,1, 32'h48,      0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'h300,     1,1, 32'h300,     0,0,0,32'h4C));
    vq.push_back(mk(1,1,2'b00,0,16'h0,26'h0,32'h0,       1,0, 32'h0,       0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b11,0,16'h0,26'h0,32'hFFFFFFFC,0,0, 32'hFFFFFFFC,0,1,0,32'h0));
    vq.push_back(mk(0,1,2'b00,0,16'h0,26'h0,32'h0,       0,0, 32'h0,       0,1,0,32'h0));

    foreach (vq[i]) begin
      @(negedge CLK);
      drive(vq[i]);
      @(posedge CLK);
      #1;
      check_vec(i, vq[i]);
    end

    // misaligned jr held for two commits, then a good commit clears the flag
    @(negedge CLK);
    Reset = 0; pc_write = 1; pc_src = 2'b11; rs_value = 32'h201;
    push_ra = 0; pop_ra = 0;
    @(posedge CLK); #1;
    check("seq.mis1", {31'd0, misaligned}, 32'd1);
    check("seq.pc1", pc, 32'h0);
    @(posedge CLK); #1;
    check("seq.mis2", {31'd0, misaligned}, 32'd1);
    @(negedge CLK);
    rs_value = 32'h200;
    @(posedge CLK); #1;
    check("seq.mis3", {31'd0, misaligned}, 32'd0);
    check("seq.pc3", pc, 32'h200);

    // mid-run reset wipes a full stack
    @(negedge CLK);
    pc_src = 2'b00; push_ra = 1;
    repeat (4) @(posedge CLK);
    #1;
    check("seq.full", {31'd0, ras_full}, 32'd1);
    check("seq.top", ras_top, 32'h210);
    @(negedge CLK);
    Reset = 1;
    @(posedge CLK); #1;
    check("seq.rst_empty", {31'd0, ras_empty}, 32'd1);
    check("seq.rst_pc", pc, 32'h0);
    @(negedge CLK);
    Reset = 0; push_ra = 0; pc_write = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
